// File: rtl/vga_sync_pipe_if.sv
// Bundle between the raster timing stage and its neighbours.
// The neighbours are the picture generator, which supplies rgb_in, and the monitor pins.
interface vga_sync_pipe_if;
  logic [2:0]  rgb_in;
  logic [11:0] pixel_x;
  logic [11:0] pixel_y;
  logic        video_on;
  logic        p_tick;
  logic        frame_tick;
  logic        hsync;
  logic        vsync;
  logic [2:0]  rgb;

  modport master (
    input  rgb_in,
    output pixel_x, pixel_y, video_on, p_tick, frame_tick, hsync, vsync, rgb
  );

  modport slave (
    output rgb_in,
    input  pixel_x, pixel_y, video_on, p_tick, frame_tick, hsync, vsync, rgb
  );
endinterface

// File: rtl/vga_sync_pipe.sv
// 640x480@60 raster timing with a one-pixel output register stage.
// The output stage keeps hsync, vsync and the gated colour aligned at the pins.
module vga_sync_pipe #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input logic             clk,
  input logic             reset,
  vga_sync_pipe_if.master bus
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [11:0]      H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [11:0]      V_LAST    = 12'(V_TOTAL - 1);
  localparam logic [11:0]      H_VIS     = 12'(H_DISPLAY);
  localparam logic [11:0]      V_VIS     = 12'(V_DISPLAY);
  localparam logic [11:0]      HS_START  = 12'(H_DISPLAY + H_FRONT);
  localparam logic [11:0]      HS_END    = 12'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [11:0]      VS_START  = 12'(V_DISPLAY + V_FRONT);
  localparam logic [11:0]      VS_END    = 12'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [11:0]      h_count_q, h_count_d;
  logic [11:0]      v_count_q, v_count_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [2:0]       rgb_q, rgb_d;

  logic p_tick, h_end, v_end, video_on, hsync_raw, vsync_raw;

  always_comb begin
    p_tick    = (div_q == DIV_LAST);
    h_end     = (h_count_q == H_LAST);
    v_end     = (v_count_q == V_LAST);
    video_on  = (h_count_q < H_VIS) && (v_count_q < V_VIS);
    hsync_raw = !((h_count_q >= HS_START) && (h_count_q <= HS_END));
    vsync_raw = !((v_count_q >= VS_START) && (v_count_q <= VS_END));

    div_d     = p_tick ? '0 : div_q + DIV_W'(1);
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    rgb_d     = rgb_q;

    // Output register samples the current pixel, so the pins trail the counters by one pixel.
    if (p_tick) begin
      h_count_d = h_end ? 12'd0 : h_count_q + 12'd1;
      if (h_end) begin
        v_count_d = v_end ? 12'd0 : v_count_q + 12'd1;
      end
      hsync_d = hsync_raw;
      vsync_d = vsync_raw;
      rgb_d   = video_on ? bus.rgb_in : 3'b000;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      h_count_q <= 12'd0;
      v_count_q <= 12'd0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      rgb_q     <= 3'b000;
    end else begin
      div_q     <= div_d;
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      rgb_q     <= rgb_d;
    end
  end

  assign bus.pixel_x    = h_count_q;
  assign bus.pixel_y    = v_count_q;
  assign bus.video_on   = video_on;
  assign bus.p_tick     = p_tick;
  assign bus.frame_tick = p_tick && h_end && v_end;
  assign bus.hsync      = hsync_q;
  assign bus.vsync      = vsync_q;
  assign bus.rgb        = rgb_q;
endmodule

// File: doc/vga_sync_pipe.md
# vga_sync_pipe

Upstream timing stage for the VGA display path: generates 640x480@60 Hz raster timing from the system clock, publishing the current pixel coordinates and `video_on` to the picture generator (the breakout game renderer). It then registers the generator's returned 3-bit colour together with delayed `hsync`/`vsync`, so that all outputs driving the monitor are pixel-aligned. It also emits a one-clock `frame_tick` for frame-rate logic.

## Interface
- `H_DISPLAY`, default 640: visible pixels per line.
- `H_FRONT`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: horizontal sync width, in pixels.
- `H_BACK`, default 48: horizontal back porch, in pixels.
- `V_DISPLAY`, default 480: visible lines.
- `V_FRONT`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vertical sync width, in lines.
- `V_BACK`, default 33: vertical back porch, in lines.
- `CLK_DIV`, default 2: `clk` cycles per pixel; minimum 1 (50 MHz clk gives a 25 MHz pixel rate).
- `clk`  in  1  system clock; all state is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rgb_in`  in  3  colour from the picture generator for the current `pixel_x`/`pixel_y`.
- `pixel_x`  out  12  horizontal counter, 0..H_TOTAL-1 (H_TOTAL = 800).
- `pixel_y`  out  12  vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525).
- `video_on`  out  1  high when `pixel_x` < H_DISPLAY and `pixel_y` < V_DISPLAY.
- `p_tick`  out  1  pixel-enable strobe, one `clk` wide.
- `frame_tick`  out  1  one-`clk` pulse on the last pixel of each frame.
- `hsync`  out  1  registered horizontal sync, active-low.
- `vsync`  out  1  registered vertical sync, active-low.
- `rgb`  out  3  registered colour to the DAC/pins; forced to 0 during blanking.

## Operation
- **Pixel divider `div`:** counts 0..CLK_DIV-1 and wraps.
  - `p_tick` = (`div` == CLK_DIV-1), decoded combinationally from the register.
  - With CLK_DIV = 1, `p_tick` is constantly 1.
- **Horizontal counter `h_count`:** advances only on `p_tick`.
  - At H_TOTAL-1 it wraps to 0.
- **Vertical counter `v_count`:** advances only on a `p_tick` where `h_count` wraps.
  - At V_TOTAL-1 it wraps to 0.
- `pixel_x` = `h_count` and `pixel_y` = `v_count`, driven directly from the registers (no decode delay). Counter widths are 12 bits, zero-extended.
- `video_on` is combinational from the counters.
- **Raw horizontal sync:** low for `h_count` in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
- **Raw vertical sync:** low for `v_count` in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491.
- **Output stage:** loads only on `p_tick`; otherwise holds.
  - `hsync` <= raw hsync.
  - `vsync` <= raw vsync.
  - `rgb` <= `video_on` ? `rgb_in` : 0.
- `frame_tick` = `p_tick` && `h_count` == H_TOTAL-1 && `v_count` == V_TOTAL-1.
- **Downstream contract:** the picture generator must present `rgb_in` combinationally from `pixel_x`/`pixel_y` within one pixel period.

## Timing
- **Reset values:**
  - Counters: `div` = 0, `h_count` = 0, `v_count` = 0.
  - Outputs: `hsync` = 1, `vsync` = 1, `rgb` = 0, `video_on` = 1, `frame_tick` = 0.
  - `p_tick` = 0 (1 when CLK_DIV = 1).
- **Reset mid-frame:** all state returns to the reset values asynchronously. The first `p_tick` after release occurs CLK_DIV-1 edges later.
- **Counter timing:**
  - Each (`pixel_x`, `pixel_y`) value is held for exactly CLK_DIV `clk` cycles.
  - Line period = 800×CLK_DIV clocks.
  - Frame period = 420000×CLK_DIV clocks.
- **Output alignment:** `hsync`, `vsync` and `rgb` lag the counters by exactly one pixel (CLK_DIV clocks) and are mutually aligned. Total latency from coordinate to pin is one pixel.
- **Line wrap:** on the same `p_tick`, `h_count` goes 799→0 and `v_count` advances.
- **Frame wrap:** at (799, 524) both counters wrap to (0, 0) and `frame_tick` fires on that same `clk`.
- **Blanking:** `rgb_in` changes during blanking never reach `rgb`.

## Test plan
- **Reset release, CLK_DIV = 2:**
  - `p_tick` is high on `clk` cycles 1, 3, 5, …
  - `pixel_x` reads 0,0,1,1,2,…
  - `hsync` = `vsync` = 1 and `rgb` = 0 before the first `p_tick`.
- **Horizontal sync:**
  - `hsync` falls one pixel after `pixel_x` = 656.
  - It stays low for exactly 96 pixels (192 clocks).
  - `video_on` falls at `pixel_x` = 640.
- **Vertical sync:**
  - `vsync` is low for exactly 2 lines (1600 clocks), starting one pixel after (`pixel_x` = 0, `pixel_y` = 490).
  - `pixel_y` reaches 524, then returns to 0.
- **Frame timing:** `frame_tick` pulses once every 840000 clocks, each pulse exactly one `clk` wide.
- **Colour gating:**
  - Drive `rgb_in` = 3'b101 constantly.
  - `rgb` = 101 for visible pixels and 0 from one pixel after `pixel_x` = 640 through one pixel after `pixel_x` = 799.
- **Reset mid-frame:**
  - Assert `reset` at `pixel_y` = 300.
  - All outputs take their reset values immediately.
  - After release, counting restarts from (0, 0).
